// File: rtl/parity_frame_checker.sv
// parity_frame_checker: LSB-first serial frame receiver with on-the-fly XOR parity check
// Optional feature macro PARITY_ERR_COUNT_EN adds a saturating parity-error counter (err_count, err_clr).
module parity_frame_checker #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              frame_start,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy
`ifdef PARITY_ERR_COUNT_EN
  ,
  input  logic              err_clr,
  output logic [7:0]        err_count
`endif
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              acc;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] bit_mask;
  logic              start;
  logic              take;
  logic              par_done;
  logic              par_bad;
  assign start    = bit_valid & frame_start;
  assign take     = bit_valid & ~frame_start & (state == DATA);
  assign par_done = bit_valid & ~frame_start & (state == PAR);
  assign par_bad  = acc ^ bit_in ^ (ODD_PARITY != 0);
  assign bit_mask = DATA_W'(1) << cnt;
  // Frame FSM: a qualified frame_start always begins a new frame, aborting any partial one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      if (start) begin
        shreg <= DATA_W'(bit_in);
        acc   <= bit_in;
        cnt   <= CW'(1);
        state <= DATA_W > 1 ? DATA : PAR;
        busy  <= 1'b1;
      end else if (take) begin
        shreg <= bit_in ? (shreg | bit_mask) : (shreg & ~bit_mask);
        acc   <= acc ^ bit_in;
        cnt   <= cnt + 1'b1;
        state <= cnt == CW'(DATA_W - 1) ? PAR : DATA;
      end else if (par_done) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
        parity_err <= par_bad;
        cnt        <= '0;
        state      <= IDLE;
        busy       <= 1'b0;
      end
    end
`ifdef PARITY_ERR_COUNT_EN
  // Saturating bad-frame counter, updated on the edge that raises data_valid; clear has priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_count <= '0;
    else if (err_clr) err_count <= '0;
    else if (par_done && par_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Serial receive-side parity checker, the far end of the team's XOR parity generator path. Deserialises a framed LSB-first bitstream of DATA_W data bits plus one parity bit and accumulates XOR parity on the fly. Presents the recovered word with a one-cycle valid pulse and a parity-error flag. Sits between a serial link front end and the byte-consuming logic.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..32)
ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
bit_in  input  1  serial data bit, sampled only when bit_valid=1
bit_valid  input  1  qualifies bit_in this cycle
frame_start  input  1  marks the bit on bit_in as data bit 0; ignored unless bit_valid=1
data_out  output  DATA_W  recovered word, bit 0 = first received bit
data_valid  output  1  one-cycle pulse: frame complete, data_out/parity_err valid
parity_err  output  1  1 = received parity mismatched; meaningful only with data_valid
busy  output  1  1 while in DATA or PAR state

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values: data_out=0, data_valid=0, parity_err=0, busy=0, FSM=IDLE, bit counter=0, parity accumulator=0, shift register=0.
- FSM states: IDLE, DATA, PAR.
- IDLE: on bit_valid&frame_start: shreg[0]=bit_in, acc=bit_in, cnt=1; go to DATA if DATA_W>1, else to PAR. bit_valid without frame_start is discarded.
- DATA: on bit_valid: shreg[cnt]=bit_in, acc^=bit_in, cnt++. When the bit just taken is bit DATA_W-1, go to PAR. Cycles with bit_valid=0 hold all state (no timeout).
- PAR: on bit_valid: parity_err <= acc ^ bit_in ^ ODD_PARITY; data_out <= shreg; data_valid <= 1; go to IDLE.
- Latency: data_valid rises the cycle after the parity bit is sampled and lasts exactly 1 cycle. data_out holds its value until the next completed frame. parity_err returns to 0 when data_valid drops.
- Restart: frame_start&bit_valid in DATA or PAR aborts the current frame with no data_valid, and the bit is taken as bit 0 of a new frame (same action as IDLE).
- Back-to-back frames: frame_start may arrive in the cycle after the parity bit. The FSM is already in IDLE then, so no bubble is needed.
- busy=1 in DATA and PAR (registered from the FSM state).
- Reset mid-frame: all state is cleared immediately. Any partial frame is lost and no data_valid is produced.

Optional Feature:
PARITY_ERR_COUNT_EN. When defined, the block adds output err_count [7:0]. It increments in the same cycle data_valid&parity_err is asserted, saturates at 255, and resets to 0 on rst_n. It also adds input err_clr [0:0]: a synchronous clear that wins over a simultaneous increment. When not defined, neither port exists and there is no counter logic.

Test Plan:
- DATA_W=8, even parity. Bits 1,0,1,0,0,1,0,1 (first with frame_start), then parity 0, all bit_valid=1 → data_out=0xA5, data_valid pulse 1 cycle after parity bit, parity_err=0.
- Same frame with parity bit 1 → data_out=0xA5, parity_err=1. With ODD_PARITY=1 and parity 1 → parity_err=0.
- Frame 0x3C with random bit_valid=0 gaps of 0–5 cycles between bits → data_out=0x3C, parity_err=0. Exactly one data_valid; busy=1 from the first bit until the parity bit.
- Abort: 4 bits of a frame, then frame_start with a new 0xFF frame and parity 0 → only one data_valid, data_out=0xFF, parity_err=0.
- Reset: assert rst_n=0 after bit 5 of a frame, release, send full frame 0x01 with parity 1 → all outputs 0 during reset. No pulse for the aborted frame; then data_out=0x01, parity_err=0.
- PARITY_ERR_COUNT_EN: 257 consecutive bad-parity frames → err_count=255. err_clr with a simultaneous bad frame → err_count=0.
